// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : traffic_pkg
// Purpose : Lamp codes, phase encoding and shared helpers for the traffic
//           light controllers.
// Rev     : 1.0
// ============================================================================
package traffic_pkg;

   typedef logic [2:0] lamp_t;

   localparam lamp_t c_lamp_red    = 3'b100;
   localparam lamp_t c_lamp_yellow = 3'b010;
   localparam lamp_t c_lamp_green  = 3'b001;
   localparam lamp_t c_lamp_off    = 3'b000;

   typedef enum logic [1:0] {
      PH_GREEN  = 2'd0,
      PH_YELLOW = 2'd1,
      PH_ALLRED = 2'd2,
      PH_FLASH  = 2'd3
   } phase_t;

   // Phase lengths inherited from the fixed two-way controller
   localparam int c_def_green_cyc  = 6;
   localparam int c_def_yellow_cyc = 2;
   localparam int c_def_allred_cyc = 1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : traffic_phase_timer
// Purpose : Loadable down-counter; done while the count sits at zero.
// Rev     : 1.0
// ============================================================================
module traffic_phase_timer #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] r_count;

   // clear reloads regardless of enable so forced transitions restart timing
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_count <= RESET_VAL;
      else if (clear)
         r_count <= load_val;
      else if (enable && (r_count != '0))
         r_count <= r_count - 1'b1;
   end

   assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/traffic_ctrl_ndir.sv
`default_nettype none
// ============================================================================
// Module  : traffic_ctrl_ndir
// Purpose : Round-robin N-approach light controller with walk extension,
//           hold and flashing-red failsafe.
// Rev     : 1.0
// ============================================================================
module traffic_ctrl_ndir
   import traffic_pkg::*;
#(
   parameter int NUM_DIR    = 2,
   parameter int GREEN_CYC  = c_def_green_cyc,
   parameter int YELLOW_CYC = c_def_yellow_cyc,
   parameter int ALLRED_CYC = c_def_allred_cyc,
   parameter int PED_EXT    = 4,
   parameter int FLASH_HALF = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       flash,
   input  logic [NUM_DIR-1:0]         ped_req,
   output logic [3*NUM_DIR-1:0]       light,
   output logic [NUM_DIR-1:0]         ped_walk,
   output logic [$clog2(NUM_DIR)-1:0] cur_dir,
   output logic [1:0]                 cur_phase
);

   localparam int c_dw     = $clog2(NUM_DIR);
   localparam int c_ar_len = max_int(ALLRED_CYC, 1);
   localparam int c_tw     = $clog2(max_int(max_int(GREEN_CYC + PED_EXT, YELLOW_CYC),
                                            max_int(ALLRED_CYC, 2 * FLASH_HALF)) + 1);

   // Timer load values are length-1: the phase ends on the edge that sees zero
   localparam logic [c_tw-1:0] c_ld_green     = c_tw'(GREEN_CYC - 1);
   localparam logic [c_tw-1:0] c_ld_green_ext = c_tw'(GREEN_CYC + PED_EXT - 1);
   localparam logic [c_tw-1:0] c_ld_yellow    = c_tw'(YELLOW_CYC - 1);
   localparam logic [c_tw-1:0] c_ld_allred    = c_tw'(c_ar_len - 1);
   localparam logic [c_tw-1:0] c_ld_flash     = c_tw'(FLASH_HALF - 1);

   phase_t             r_state;
   logic [c_dw-1:0]    r_dir;
   logic               r_walk;
   logic               r_flash_off;
   logic               r_from_flash;
   logic [NUM_DIR-1:0] r_pend;

   phase_t             w_state_n;
   logic [c_dw-1:0]    w_dir_n;
   logic [c_dw-1:0]    w_dir_inc;
   logic [c_dw-1:0]    w_green_dir;
   logic               w_walk_n;
   logic               w_off_n;
   logic               w_ff_n;
   logic               w_enter_green;
   logic               w_load;
   logic [c_tw-1:0]    w_load_val;
   logic               w_done;
   logic [NUM_DIR-1:0] w_pend_now;
   logic [NUM_DIR-1:0] w_serve_mask;

   assign w_pend_now = r_pend | ped_req;
   assign w_dir_inc  = (r_dir == c_dw'(NUM_DIR - 1)) ? '0 : r_dir + 1'b1;

   traffic_phase_timer #(
      .WIDTH     (c_tw),
      .RESET_VAL (c_ld_green)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .clear    (w_load),
      .load_val (w_load_val),
      .done     (w_done)
   );

   always_comb begin
      w_state_n     = r_state;
      w_dir_n       = r_dir;
      w_walk_n      = r_walk;
      w_off_n       = r_flash_off;
      w_ff_n        = r_from_flash;
      w_load        = 1'b0;
      w_load_val    = c_ld_green;
      w_enter_green = 1'b0;
      w_green_dir   = w_dir_inc;
      w_serve_mask  = '0;

      if (flash) begin
         if (r_state != PH_FLASH) begin
            w_state_n  = PH_FLASH;
            w_off_n    = 1'b0;
            w_walk_n   = 1'b0;
            w_load     = 1'b1;
            w_load_val = c_ld_flash;
         end else if (enable && w_done) begin
            w_off_n    = ~r_flash_off;
            w_load     = 1'b1;
            w_load_val = c_ld_flash;
         end
      end else if (enable) begin
         case (r_state)
            PH_GREEN: begin
               if (w_done) begin
                  w_state_n  = PH_YELLOW;
                  w_walk_n   = 1'b0;
                  w_load     = 1'b1;
                  w_load_val = c_ld_yellow;
               end
            end
            PH_YELLOW: begin
               if (w_done) begin
                  if (ALLRED_CYC == 0) begin
                     w_enter_green = 1'b1;
                  end else begin
                     w_state_n  = PH_ALLRED;
                     w_load     = 1'b1;
                     w_load_val = c_ld_allred;
                  end
               end
            end
            PH_ALLRED: begin
               if (w_done) begin
                  w_enter_green = 1'b1;
                  if (r_from_flash)
                     w_green_dir = '0;
                  w_ff_n = 1'b0;
               end
            end
            default: begin
               // Leaving failsafe: clearance then restart at approach 0
               w_state_n  = PH_ALLRED;
               w_ff_n     = 1'b1;
               w_walk_n   = 1'b0;
               w_load     = 1'b1;
               w_load_val = c_ld_allred;
            end
         endcase
      end

      if (w_enter_green) begin
         w_state_n                 = PH_GREEN;
         w_dir_n                   = w_green_dir;
         w_walk_n                  = w_pend_now[w_green_dir];
         w_serve_mask[w_green_dir] = w_walk_n;
         w_load                    = 1'b1;
         w_load_val                = w_walk_n ? c_ld_green_ext : c_ld_green;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= PH_GREEN;
         r_dir        <= '0;
         r_walk       <= 1'b0;
         r_flash_off  <= 1'b0;
         r_from_flash <= 1'b0;
         r_pend       <= '0;
      end else begin
         r_state      <= w_state_n;
         r_dir        <= w_dir_n;
         r_walk       <= w_walk_n;
         r_flash_off  <= w_off_n;
         r_from_flash <= w_ff_n;
         r_pend       <= w_pend_now & ~w_serve_mask;
      end
   end

   generate
      for (genvar d = 0; d < NUM_DIR; d++) begin : g_lamp
         logic w_is_cur;
         assign w_is_cur = (r_dir == c_dw'(d));
         assign light[3*d +: 3] =
            (r_state == PH_FLASH)                 ? (r_flash_off ? c_lamp_off : c_lamp_red) :
            ((r_state == PH_ALLRED) || !w_is_cur) ? c_lamp_red :
            (r_state == PH_YELLOW)                ? c_lamp_yellow : c_lamp_green;
         assign ped_walk[d] = r_walk && (r_state == PH_GREEN) && w_is_cur;
      end
   endgenerate

   assign cur_dir   = r_dir;
   assign cur_phase = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_ctrl_ndir.sv
`default_nettype none
// ============================================================================
// Module  : tb_traffic_ctrl_ndir
// Purpose : Scoreboard bench for two controller builds against a cycle model.
// Rev     : 1.0
// ============================================================================
module tb_traffic_ctrl_ndir;

   typedef struct packed {
      logic [23:0] light;
      logic [7:0]  walk;
      logic [2:0]  dir;
      logic [1:0]  ph;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        flash = 1'b0;
   logic [7:0]  ped_req = 8'h00;

   logic [11:0] light0;
   logic [3:0]  walk0;
   logic [1:0]  dir0;
   logic [1:0]  ph0;
   logic [8:0]  light1;
   logic [2:0]  walk1;
   logic [1:0]  dir1;
   logic [1:0]  ph1;

   int total = 0;
   int bad   = 0;

   obs_t q0[$];
   obs_t q1[$];

   // Build parameters per instance: 0 = defaults with 4 approaches, 1 = no all-red
   int p_n [2] = '{4, 3};
   int p_g [2] = '{6, 3};
   int p_y [2] = '{2, 1};
   int p_ar[2] = '{1, 0};
   int p_pe[2] = '{4, 2};
   int p_fh[2] = '{4, 2};

   // Model: phase 0..3, elapsed cycles in phase, phase length
   int         m_ph  [2];
   int         m_dir [2];
   int         m_el  [2];
   int         m_len [2];
   bit         m_walk[2];
   bit         m_off [2];
   bit         m_ff  [2];
   logic [7:0] m_pend[2];

   always #5 clk = ~clk;

   traffic_ctrl_ndir #(
      .NUM_DIR(4), .GREEN_CYC(6), .YELLOW_CYC(2), .ALLRED_CYC(1), .PED_EXT(4), .FLASH_HALF(4)
   ) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .flash(flash), .ped_req(ped_req[3:0]),
      .light(light0), .ped_walk(walk0), .cur_dir(dir0), .cur_phase(ph0)
   );

   traffic_ctrl_ndir #(
      .NUM_DIR(3), .GREEN_CYC(3), .YELLOW_CYC(1), .ALLRED_CYC(0), .PED_EXT(2), .FLASH_HALF(2)
   ) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .flash(flash), .ped_req(ped_req[2:0]),
      .light(light1), .ped_walk(walk1), .cur_dir(dir1), .cur_phase(ph1)
   );

   task automatic m_reset(input int i);
      m_ph[i] = 0; m_dir[i] = 0; m_el[i] = 0; m_len[i] = p_g[i];
      m_walk[i] = 1'b0; m_off[i] = 1'b0; m_ff[i] = 1'b0; m_pend[i] = 8'h00;
   endtask

   task automatic m_green(input int i, input int k);
      m_ph[i] = 0; m_dir[i] = k; m_el[i] = 0;
      m_walk[i] = m_pend[i][k];
      m_len[i] = p_g[i] + (m_walk[i] ? p_pe[i] : 0);
      m_pend[i][k] = 1'b0;
   endtask

   task automatic m_step(input int i, input bit en, input bit fl, input logic [7:0] pr);
      logic [7:0] mask;
      mask = 8'((1 << p_n[i]) - 1);
      m_pend[i] = m_pend[i] | (pr & mask);
      if (fl) begin
         if (m_ph[i] != 3) begin
            m_ph[i] = 3; m_el[i] = 0; m_off[i] = 1'b0; m_walk[i] = 1'b0;
         end else if (en) begin
            if (m_el[i] == p_fh[i] - 1) begin
               m_off[i] = !m_off[i]; m_el[i] = 0;
            end else m_el[i]++;
         end
      end else if (en) begin
         if (m_ph[i] == 3) begin
            m_ph[i] = 2; m_el[i] = 0; m_len[i] = (p_ar[i] > 0) ? p_ar[i] : 1; m_ff[i] = 1'b1;
         end else if (m_el[i] < m_len[i] - 1) begin
            m_el[i]++;
         end else begin
            case (m_ph[i])
               0: begin m_ph[i] = 1; m_el[i] = 0; m_len[i] = p_y[i]; m_walk[i] = 1'b0; end
               1: begin
                  if (p_ar[i] == 0) m_green(i, (m_dir[i] + 1) % p_n[i]);
                  else begin m_ph[i] = 2; m_el[i] = 0; m_len[i] = p_ar[i]; end
               end
               default: begin
                  m_green(i, m_ff[i] ? 0 : (m_dir[i] + 1) % p_n[i]);
                  m_ff[i] = 1'b0;
               end
            endcase
         end
      end
   endtask

   function automatic obs_t m_obs(input int i);
      obs_t e;
      e = '0;
      for (int d = 0; d < p_n[i]; d++) begin
         logic [2:0] l;
         if (m_ph[i] == 3)                        l = m_off[i] ? 3'b000 : 3'b100;
         else if (m_ph[i] == 2 || d != m_dir[i])  l = 3'b100;
         else if (m_ph[i] == 1)                   l = 3'b010;
         else                                     l = 3'b001;
         e.light[3*d +: 3] = l;
         e.walk[d] = (m_ph[i] == 0) && m_walk[i] && (d == m_dir[i]);
      end
      e.dir = 3'(m_dir[i]);
      e.ph  = 2'(m_ph[i]);
      return e;
   endfunction

   function automatic obs_t act(input int i);
      obs_t a;
      a = '0;
      if (i == 0) begin
         a.light[11:0] = light0; a.walk[3:0] = walk0; a.dir[1:0] = dir0; a.ph = ph0;
      end else begin
         a.light[8:0] = light1; a.walk[2:0] = walk1; a.dir[1:0] = dir1; a.ph = ph1;
      end
      return a;
   endfunction

   task automatic check(input int i, input obs_t got, input obs_t exp, input string nm);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t got light=%h walk=%h dir=%0d ph=%0d want light=%h walk=%h dir=%0d ph=%0d",
                  nm, i, $time, got.light, got.walk, got.dir, got.ph,
                  exp.light, exp.walk, exp.dir, exp.ph);
      end
   endtask

   // One stimulus cycle: drive inputs, advance the model, queue the expectation
   task automatic cycle(input bit r, input bit en, input bit fl, input logic [7:0] pr);
      @(negedge clk);
      reset = r; enable = en; flash = fl; ped_req = pr;
      for (int i = 0; i < 2; i++) begin
         if (r) m_reset(i);
         else   m_step(i, en, fl, pr);
      end
      if (r) begin
         #1;
         check(0, act(0), m_obs(0), "async_reset");
         check(1, act(1), m_obs(1), "async_reset");
      end
      q0.push_back(m_obs(0));
      q1.push_back(m_obs(1));
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) check(0, act(0), q0.pop_front(), "cycle");
         if (q1.size() > 0) check(1, act(1), q1.pop_front(), "cycle");
      end
   end

   initial begin : stimulus
      bit fl_lvl;
      fl_lvl = 1'b0;
      m_reset(0);
      m_reset(1);

      repeat (2) cycle(1'b1, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 40; c++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 45; c++)
         cycle(1'b0, 1'b1, 1'b0, (c == 2 || c == 12) ? 8'h02 : 8'h00);

      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 22; c++)
         cycle(1'b0, !(c >= 3 && c < 8), 1'b0, 8'h00);

      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 32; c++)
         cycle(1'b0, 1'b1, (c >= 7 && c < 20), 8'h00);

      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 7; c++)
         cycle(1'b0, 1'b1, 1'b0, (c == 1) ? 8'h0F : 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      for (int c = 0; c < 30; c++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

      for (int c = 0; c < 1500; c++) begin
         logic [7:0] pr;
         if ($urandom_range(79) == 0) fl_lvl = !fl_lvl;
         for (int b = 0; b < 8; b++) pr[b] = ($urandom_range(11) == 0);
         cycle($urandom_range(399) == 0, $urandom_range(7) != 0, fl_lvl, pr);
      end

      repeat (3) @(posedge clk);
      #2;
      if (q0.size() != 0 || q1.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
